spi_cmd_sequencer: RTL and testbench

- Upstream feeder for the SPI master, between the PCI register file and the SPI master's PCI-side port.
- Queues host SPI command words with chip-select codes and issues them one at a time.
- Runs the master's START/DONE four-phase handshake and captures read-back data for read commands (SPI_I[3:0] = 4'b1110).
- Reports busy, timeout and overflow status to PCI.

---
 rtl/spi_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// Command FIFO and START/DONE handshake sequencer feeding the SPI master.
// Issues one queued command at a time, captures read-back data and reports status.
module spi_cmd_sequencer #(
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [3:0] READ_OPCODE    = 4'b1110
) (
    input  logic                          BOARD_CLOCK,
    input  logic                          RST,
    input  logic [31:0]                   CMD_DATA_I,
    input  logic [1:0]                    CMD_SEL_I,
    input  logic                          CMD_WR_I,
    output logic                          CMD_FULL_O,
    output logic [$clog2(FIFO_DEPTH):0]   CMD_COUNT_O,
    output logic                          CMD_OVF_O,
    output logic [31:0]                   RD_DATA_O,
    output logic                          RD_VALID_O,
    input  logic                          RD_ACK_I,
    output logic                          BUSY_O,
    output logic                          TIMEOUT_O,
    input  logic                          CLR_ERR_I,
    output logic [31:0]                   SPI_I_O,
    output logic [1:0]                    SPI_SEL_O,
    output logic                          SPI_STAR_O,
    input  logic                          SPI_DONE_I,
    input  logic [31:0]                   SPI_O_I
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {ST_WAIT_LOW, ST_IDLE, ST_ISSUE} state_t;

    logic            done_meta_reg;
    logic            done_s_reg;
    logic [33:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            full_reg;
    logic            ovf_reg;
    logic            push;
    logic            pop;
    logic            idle_next;
    state_t          state_reg;
    logic [TW-1:0]   timer_reg;
    logic            is_read_reg;
    logic [31:0]     spi_i_reg;
    logic [1:0]      spi_sel_reg;
    logic            star_reg;
    logic [31:0]     rd_data_reg;
    logic            rd_valid_reg;
    logic            timeout_reg;
    logic            busy_reg;

    // Synchronizer resets to "done" so a master still showing DONE after reset is absorbed.
    always_ff @(posedge BOARD_CLOCK) begin
        if (RST) begin
            done_meta_reg <= 1'b1;
            done_s_reg    <= 1'b1;
        end else begin
            done_meta_reg <= SPI_DONE_I;
            done_s_reg    <= done_meta_reg;
        end
    end

    always_comb begin
        push       = CMD_WR_I && (count_reg < CW'(FIFO_DEPTH));
        pop        = (state_reg == ST_IDLE) && (count_reg != '0);
        count_next = count_reg + CW'(push) - CW'(pop);
        idle_next  = ((state_reg == ST_WAIT_LOW) && !done_s_reg) ||
                     ((state_reg == ST_IDLE) && !pop);
    end

    always_ff @(posedge BOARD_CLOCK) begin
        if (push)
            mem[wr_ptr_reg] <= {CMD_SEL_I, CMD_DATA_I};
    end

    always_ff @(posedge BOARD_CLOCK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(FIFO_DEPTH));
            if (CMD_WR_I && !push)
                ovf_reg <= 1'b1;
            else if (CLR_ERR_I)
                ovf_reg <= 1'b0;
        end
    end

    always_ff @(posedge BOARD_CLOCK) begin
        if (RST) begin
            state_reg    <= ST_WAIT_LOW;
            rd_ptr_reg   <= '0;
            timer_reg    <= '0;
            is_read_reg  <= 1'b0;
            spi_i_reg    <= '0;
            spi_sel_reg  <= '0;
            star_reg     <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            busy_reg <= (count_next != '0) || !idle_next;
            // Clears are defaults; a capture or a timeout below overrides them.
            if (RD_ACK_I)
                rd_valid_reg <= 1'b0;
            if (CLR_ERR_I)
                timeout_reg <= 1'b0;
            case (state_reg)
                ST_WAIT_LOW: begin
                    star_reg <= 1'b0;
                    if (!done_s_reg)
                        state_reg <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pop) begin
                        spi_i_reg   <= mem[rd_ptr_reg][31:0];
                        spi_sel_reg <= mem[rd_ptr_reg][33:32];
                        is_read_reg <= (mem[rd_ptr_reg][3:0] == READ_OPCODE);
                        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                        timer_reg   <= '0;
                        star_reg    <= 1'b1;
                        state_reg   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (done_s_reg) begin
                        // An unread capture stalls a read with START held and the timer frozen.
                        if (!(is_read_reg && rd_valid_reg)) begin
                            if (is_read_reg) begin
                                rd_data_reg  <= SPI_O_I;
                                rd_valid_reg <= 1'b1;
                            end
                            star_reg  <= 1'b0;
                            state_reg <= ST_WAIT_LOW;
                        end
                    end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_reg <= 1'b1;
                        star_reg    <= 1'b0;
                        state_reg   <= ST_WAIT_LOW;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: begin
                    star_reg  <= 1'b0;
                    state_reg <= ST_WAIT_LOW;
                end
            endcase
        end
    end

    assign CMD_FULL_O  = full_reg;
    assign CMD_COUNT_O = count_reg;
    assign CMD_OVF_O   = ovf_reg;
    assign RD_DATA_O   = rd_data_reg;
    assign RD_VALID_O  = rd_valid_reg;
    assign BUSY_O      = busy_reg;
    assign TIMEOUT_O   = timeout_reg;
    assign SPI_I_O     = spi_i_reg;
    assign SPI_SEL_O   = spi_sel_reg;
    assign SPI_STAR_O  = star_reg;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer with a behavioural SPI master and host reader.
// Expected issue order and read-back data come from queues filled as stimulus is applied.
module tb_spi_cmd_sequencer;

    localparam int D = 4;
    localparam int T = 256;
    localparam int M_NORMAL = 0;
    localparam int M_STALL  = 1;
    localparam int M_HIGH   = 2;

    logic        clk = 1'b0;
    logic        RST;
    logic [31:0] CMD_DATA_I;
    logic [1:0]  CMD_SEL_I;
    logic        CMD_WR_I;
    logic        CMD_FULL_O;
    logic [2:0]  CMD_COUNT_O;
    logic        CMD_OVF_O;
    logic [31:0] RD_DATA_O;
    logic        RD_VALID_O;
    logic        RD_ACK_I;
    logic        BUSY_O;
    logic        TIMEOUT_O;
    logic        CLR_ERR_I;
    logic [31:0] SPI_I_O;
    logic [1:0]  SPI_SEL_O;
    logic        SPI_STAR_O;
    logic        SPI_DONE_I;
    logic [31:0] SPI_O_I;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int master_mode = M_NORMAL;
    int ack_mode = 0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_data = '0;
    logic [31:0] master_data = '0;
    logic        ovf_exp = 1'b0;
    logic [33:0] issue_q[$];
    logic [31:0] rd_q[$];

    spi_cmd_sequencer #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
        .BOARD_CLOCK(clk),
        .RST(RST),
        .CMD_DATA_I(CMD_DATA_I),
        .CMD_SEL_I(CMD_SEL_I),
        .CMD_WR_I(CMD_WR_I),
        .CMD_FULL_O(CMD_FULL_O),
        .CMD_COUNT_O(CMD_COUNT_O),
        .CMD_OVF_O(CMD_OVF_O),
        .RD_DATA_O(RD_DATA_O),
        .RD_VALID_O(RD_VALID_O),
        .RD_ACK_I(RD_ACK_I),
        .BUSY_O(BUSY_O),
        .TIMEOUT_O(TIMEOUT_O),
        .CLR_ERR_I(CLR_ERR_I),
        .SPI_I_O(SPI_I_O),
        .SPI_SEL_O(SPI_SEL_O),
        .SPI_STAR_O(SPI_STAR_O),
        .SPI_DONE_I(SPI_DONE_I),
        .SPI_O_I(SPI_O_I)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model FIFO: a write is kept iff fewer than D commands are awaiting issue.
    task automatic push(input logic [1:0] sel, input logic [31:0] data);
        if (issue_q.size() < D)
            issue_q.push_back({sel, data});
        else
            ovf_exp = 1'b1;
        CMD_SEL_I  = sel;
        CMD_DATA_I = data;
        CMD_WR_I   = 1'b1;
        step();
        CMD_WR_I   = 1'b0;
    endtask

    task automatic pulse_clr();
        CLR_ERR_I = 1'b1;
        step();
        CLR_ERR_I = 1'b0;
        ovf_exp   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && (issue_q.size() != 0 || rd_q.size() != 0 || BUSY_O); i++)
            step();
        check({name, "_issue_q"}, 64'(issue_q.size()), 64'd0);
        check({name, "_rd_q"}, 64'(rd_q.size()), 64'd0);
        check({name, "_busy"}, BUSY_O, 1'b0);
    endtask

    // Behavioural SPI master: DONE follows START after a random delay, data held while DONE.
    initial begin
        int mdly = 0;
        SPI_DONE_I = 1'b0;
        SPI_O_I    = '0;
        forever begin
            step();
            if (master_mode == M_HIGH) begin
                SPI_DONE_I = 1'b1;
            end else if (master_mode == M_STALL) begin
                SPI_DONE_I = 1'b0;
            end else if (SPI_STAR_O && !SPI_DONE_I) begin
                if (mdly == 0) begin
                    SPI_O_I     = use_fixed ? fixed_data : $urandom;
                    master_data = SPI_O_I;
                    SPI_DONE_I  = 1'b1;
                    mdly        = $urandom_range(0, 4);
                end else mdly--;
            end else if (!SPI_STAR_O && SPI_DONE_I) begin
                if (mdly == 0) begin
                    SPI_DONE_I = 1'b0;
                    mdly       = $urandom_range(0, 4);
                end else mdly--;
            end
        end
    end

    // Host reader: acknowledges captured data after a random delay when enabled.
    initial begin
        int adly = 0;
        RD_ACK_I = 1'b0;
        forever begin
            step();
            RD_ACK_I = 1'b0;
            if (ack_mode != 0 && RD_VALID_O) begin
                if (adly == 0) begin
                    RD_ACK_I = 1'b1;
                    adly     = $urandom_range(0, 5);
                end else adly--;
            end
        end
    end

    // Monitor: pops expectations on each START rise and each read capture.
    initial begin
        logic        star_prev = 1'b0;
        logic        valid_prev = 1'b0;
        logic        ack_prev = 1'b0;
        logic        rst_prev = 1'b1;
        logic [31:0] data_prev = '0;
        logic [33:0] cur_cmd = '0;
        forever begin
            @(negedge clk);
            if (!rst_prev) begin
                if (SPI_STAR_O && !star_prev) begin
                    if (issue_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL issue_order: got issue of %08h, required no issue", SPI_I_O);
                    end else begin
                        cur_cmd = issue_q.pop_front();
                        check("issue_data", SPI_I_O, cur_cmd[31:0]);
                        check("issue_sel", SPI_SEL_O, cur_cmd[33:32]);
                        $display("issue: sel=%0d data=%08h", SPI_SEL_O, SPI_I_O);
                    end
                end else if (SPI_STAR_O) begin
                    check("issue_hold", {SPI_SEL_O, SPI_I_O}, cur_cmd);
                end
                if (!SPI_STAR_O && star_prev && cur_cmd[3:0] == 4'hE)
                    rd_q.push_back(master_data);
                if (RD_VALID_O && (!valid_prev || ack_prev)) begin
                    if (rd_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rd_capture: got capture of %08h, required none", RD_DATA_O);
                    end else begin
                        check("rd_data", RD_DATA_O, rd_q.pop_front());
                        $display("capture: data=%08h", RD_DATA_O);
                    end
                end else begin
                    check("rd_data_stable", RD_DATA_O, data_prev);
                end
            end
            star_prev  = SPI_STAR_O;
            valid_prev = RD_VALID_O;
            ack_prev   = RD_ACK_I;
            data_prev  = RD_DATA_O;
            rst_prev   = RST;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish within bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        logic [31:0] d;
        RST = 1'b1;
        CMD_DATA_I = '0;
        CMD_SEL_I = '0;
        CMD_WR_I = 1'b0;
        CLR_ERR_I = 1'b0;
        repeat (3) step();
        check("rst_star", SPI_STAR_O, 1'b0);
        check("rst_count", CMD_COUNT_O, 3'd0);
        check("rst_status", {CMD_FULL_O, CMD_OVF_O, RD_VALID_O, BUSY_O, TIMEOUT_O}, 5'd0);
        check("rst_data", {RD_DATA_O, SPI_I_O, SPI_SEL_O}, 66'd0);
        RST = 1'b0;
        repeat (6) step();

        // Single write command: START one cycle after the pop, no read capture.
        ack_mode = 1;
        push(2'd1, 32'h0000_00A5);
        check("t1_count_after_push", CMD_COUNT_O, 3'd1);
        check("t1_star_before_pop", SPI_STAR_O, 1'b0);
        step();
        check("t1_star_after_pop", SPI_STAR_O, 1'b1);
        check("t1_count_after_pop", CMD_COUNT_O, 3'd0);
        for (int i = 0; i < 40 && SPI_STAR_O; i++) step();
        check("t1_star_drop", SPI_STAR_O, 1'b0);
        check("t1_rd_valid", RD_VALID_O, 1'b0);
        drain("t1");

        // Read command with fixed master data, acknowledged by the host.
        ack_mode   = 0;
        fixed_data = 32'hDEAD_BEEF;
        use_fixed  = 1'b1;
        push(2'd2, 32'h1234_567E);
        for (int i = 0; i < 60 && !RD_VALID_O; i++) step();
        check("t2_rd_valid", RD_VALID_O, 1'b1);
        check("t2_rd_data", RD_DATA_O, 32'hDEAD_BEEF);
        ack_mode = 1;
        for (int i = 0; i < 20 && RD_VALID_O; i++) step();
        check("t2_rd_ack", RD_VALID_O, 1'b0);
        use_fixed = 1'b0;
        drain("t2");

        // Overflow: master holds DONE, so nothing leaves WAIT_LOW while five writes arrive.
        master_mode = M_HIGH;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 4; i++) push(2'(i % 3), 32'h0000_1000 + 32'(i));
        check("t3_full", CMD_FULL_O, 1'b1);
        check("t3_count4", CMD_COUNT_O, 3'd4);
        check("t3_no_ovf_yet", CMD_OVF_O, 1'b0);
        push(2'd0, 32'h0000_BAD0);
        check("t3_ovf", CMD_OVF_O, ovf_exp);
        check("t3_count_kept", CMD_COUNT_O, 3'd4);
        pulse_clr();
        check("t3_ovf_clr", CMD_OVF_O, 1'b0);
        master_mode = M_NORMAL;
        drain("t3");

        // Two reads without acknowledge: the second holds START past the timeout window.
        ack_mode = 0;
        push(2'd0, 32'hAAAA_000E);
        push(2'd1, 32'hBBBB_111E);
        repeat (T + 60) step();
        check("t4_star_held", SPI_STAR_O, 1'b1);
        check("t4_done_high", SPI_DONE_I, 1'b1);
        check("t4_no_timeout", TIMEOUT_O, 1'b0);
        check("t4_valid_held", RD_VALID_O, 1'b1);
        ack_mode = 1;
        drain("t4");
        check("t4_no_timeout_end", TIMEOUT_O, 1'b0);

        // Master never answers: timeout exactly T cycles after START, then the next command runs.
        master_mode = M_STALL;
        push(2'd2, 32'h0000_5550);
        push(2'd1, 32'h0000_6661);
        for (int i = 0; i < 20 && !SPI_STAR_O; i++) step();
        check("t5_star_rise", SPI_STAR_O, 1'b1);
        c0 = cyc;
        for (int i = 0; i < T + 40 && !TIMEOUT_O; i++) step();
        check("t5_timeout_delay", 64'(cyc - c0), 64'(T));
        check("t5_timeout", TIMEOUT_O, 1'b1);
        check("t5_star_drop", SPI_STAR_O, 1'b0);
        master_mode = M_NORMAL;
        drain("t5");
        pulse_clr();
        check("t5_timeout_clr", TIMEOUT_O, 1'b0);

        // Randomised traffic with mixed reads, writes, delays and acknowledges.
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 2) != 0 && issue_q.size() < D) begin
                d = $urandom;
                if ($urandom_range(0, 9) < 4) d[3:0] = 4'hE;
                else if (d[3:0] == 4'hE) d[3:0] = 4'h5;
                push(2'($urandom_range(0, 2)), d);
            end else begin
                step();
            end
        end
        drain("rnd");
        check("rnd_timeout", TIMEOUT_O, 1'b0);
        check("rnd_ovf", CMD_OVF_O, 1'b0);

        // Reset in ISSUE with two queued; DONE held high afterwards blocks any issue.
        master_mode = M_STALL;
        push(2'd0, 32'h0000_7770);
        push(2'd1, 32'h0000_8881);
        push(2'd2, 32'h0000_9992);
        for (int i = 0; i < 20 && !SPI_STAR_O; i++) step();
        step();
        check("t6_count_before", CMD_COUNT_O, 3'd2);
        master_mode = M_HIGH;
        RST = 1'b1;
        issue_q.delete();
        step();
        RST = 1'b0;
        check("t6_star", SPI_STAR_O, 1'b0);
        check("t6_count", CMD_COUNT_O, 3'd0);
        check("t6_status", {CMD_FULL_O, CMD_OVF_O, RD_VALID_O, BUSY_O, TIMEOUT_O}, 5'd0);
        push(2'd1, 32'h0000_ABC1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t6_no_issue", SPI_STAR_O, 1'b0);
        end
        master_mode = M_NORMAL;
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
